// File: rtl/vga_vblank_arbiter_if.sv
// rtl/vga_vblank_arbiter_if.sv - request/grant handshake bundle between frame-RAM requesters and the arbiter
interface vga_vblank_arbiter_if;
  logic [1:0] i_Req;
  logic [1:0] i_Done;
  logic [1:0] o_Grant;
  logic [1:0] o_Abort;

  // Requester side: drives requests and completion pulses, observes grants/aborts
  modport master (
    output i_Req,
    output i_Done,
    input  o_Grant,
    input  o_Abort
  );

  // Arbiter side
  modport slave (
    input  i_Req,
    input  i_Done,
    output o_Grant,
    output o_Abort
  );
endinterface

// File: rtl/vga_vblank_arbiter.sv
// rtl/vga_vblank_arbiter.sv - vertical-blanking write-window arbiter with round-robin grant and frame counter
module vga_vblank_arbiter #(
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int GUARD_LINES = 2,
  parameter int MAX_HOLD    = 4096
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [9:0]           i_VPos,
  vga_vblank_arbiter_if.slave  io_Arb,
  output logic                 o_WinOpen,
  output logic                 o_Busy,
  output logic                 o_FrameTick,
  output logic [7:0]           o_FrameCnt
);

  localparam logic [9:0]  L_WIN_FIRST = 10'(V_ACTIVE);
  localparam logic [9:0]  L_WIN_END   = 10'(V_TOTAL - GUARD_LINES);
  localparam logic [15:0] L_HOLD_LAST = 16'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last, w_last_nxt;
  logic [15:0] r_hold, w_hold_nxt;
  logic [1:0]  r_abort, w_abort_nxt;
  logic        r_win, r_tick;
  logic [9:0]  r_vpos_prev;
  logic [7:0]  r_cnt;
  logic        w_win, w_tick, w_pick, w_own_idx;

  // Window and frame-start detection from the raw line number
  always_comb begin
    w_win  = (i_VPos >= L_WIN_FIRST) && (i_VPos < L_WIN_END);
    w_tick = (i_VPos == L_WIN_FIRST) && (r_vpos_prev != L_WIN_FIRST);
  end

  // Window flag, previous line sample, frame tick and frame counter
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_win       <= 1'b0;
      r_vpos_prev <= '0;
      r_tick      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_win       <= w_win;
      r_vpos_prev <= i_VPos;
      r_tick      <= w_tick;
      if (w_tick) r_cnt <= r_cnt + 8'd1;
    end
  end

  // Grant selection: a lone request wins outright, a tie goes to whoever was not served last
  always_comb begin
    w_own_idx = (r_state == OWN1);
    if (io_Arb.i_Req == 2'b11) w_pick = ~r_last;
    else                       w_pick = ~io_Arb.i_Req[0];
  end

  // Next-state logic; normal release is checked first so it overrides a simultaneous forced release
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    w_abort_nxt = 2'b00;
    case (r_state)
      IDLE: begin
        if (r_win && (|io_Arb.i_Req)) begin
          w_state_nxt = w_pick ? OWN1 : OWN0;
          w_last_nxt  = w_pick;
          w_hold_nxt  = '0;
        end
      end
      OWN0, OWN1: begin
        if (io_Arb.i_Done[w_own_idx] || !io_Arb.i_Req[w_own_idx]) begin
          w_state_nxt = IDLE;
        end else if (!r_win || (r_hold == L_HOLD_LAST)) begin
          w_state_nxt            = IDLE;
          w_abort_nxt[w_own_idx] = 1'b1;
        end else if (r_hold != 16'hFFFF) begin
          w_hold_nxt = r_hold + 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state, last-served pointer, hold counter and abort pulse registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_hold  <= '0;
      r_abort <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_hold  <= w_hold_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  assign io_Arb.o_Grant = {r_state == OWN1, r_state == OWN0};
  assign io_Arb.o_Abort = r_abort;
  assign o_Busy         = |io_Arb.o_Grant;
  assign o_WinOpen      = r_win;
  assign o_FrameTick    = r_tick;
  assign o_FrameCnt     = r_cnt;

endmodule

// File: tb/tb_vga_vblank_arbiter.sv
// tb/tb_vga_vblank_arbiter.sv - scoreboard bench for vga_vblank_arbiter (default and short-timeout instances)
module tb_vga_vblank_arbiter;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [9:0] vpos;
  logic       win0, busy0, tick0, win1, busy1, tick1;
  logic [7:0] cnt0, cnt1;

  vga_vblank_arbiter_if bus0 ();
  vga_vblank_arbiter_if bus1 ();

  vga_vblank_arbiter dut0 (
    .Clk(Clk), .Rst(Rst), .i_VPos(vpos), .io_Arb(bus0),
    .o_WinOpen(win0), .o_Busy(busy0), .o_FrameTick(tick0), .o_FrameCnt(cnt0)
  );

  vga_vblank_arbiter #(.MAX_HOLD(8)) dut1 (
    .Clk(Clk), .Rst(Rst), .i_VPos(vpos), .io_Arb(bus1),
    .o_WinOpen(win1), .o_Busy(busy1), .o_FrameTick(tick1), .o_FrameCnt(cnt1)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0] grant;
    logic [1:0] abort;
    logic       win;
    logic       busy;
    logic       tick;
    logic [7:0] cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   phase    = 0;
  int   mon_cyc  = 0;
  int   order[$];
  int   ticks    = 0;
  logic [1:0] prev_g0 = 2'b00;

  // Reference model: who owns the RAM, how long, who was served last, plus frame bookkeeping
  int         m_owner[2];
  int         m_hold[2];
  int         m_last[2];
  logic [1:0] m_abort[2];
  int         maxh[2] = '{4096, 8};
  int         m_prev;
  logic       m_win, m_tick;
  logic [7:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_hold[d]  = 0;
      m_last[d]  = 1;
      m_abort[d] = 2'b00;
    end
    m_prev = 0;
    m_win  = 1'b0;
    m_tick = 1'b0;
    m_cnt  = 8'd0;
  endtask

  task automatic model_step(input logic [9:0] vp, input logic [1:0] rq, input logic [1:0] dn);
    int k;
    for (int d = 0; d < 2; d++) begin
      m_abort[d] = 2'b00;
      if (m_owner[d] < 0) begin
        if (m_win && rq != 2'b00) begin
          if (rq == 2'b11) k = 1 - m_last[d];
          else             k = rq[0] ? 0 : 1;
          m_owner[d] = k;
          m_last[d]  = k;
          m_hold[d]  = 0;
        end
      end else begin
        k = m_owner[d];
        if (dn[k] || !rq[k]) begin
          m_owner[d] = -1;
        end else if (!m_win || m_hold[d] == maxh[d] - 1) begin
          m_owner[d]    = -1;
          m_abort[d][k] = 1'b1;
        end else if (m_hold[d] < 65535) begin
          m_hold[d] = m_hold[d] + 1;
        end
      end
    end
    m_tick = (vp == 10'd480) && (m_prev != 480);
    if (m_tick) m_cnt = m_cnt + 8'd1;
    m_prev = int'(vp);
    m_win  = (vp >= 10'd480) && (vp < 10'd523);
  endtask

  function automatic exp_t expect_of(input int d);
    exp_t e;
    e.grant = (m_owner[d] == 0) ? 2'b01 : (m_owner[d] == 1) ? 2'b10 : 2'b00;
    e.abort = m_abort[d];
    e.win   = m_win;
    e.busy  = (m_owner[d] >= 0);
    e.tick  = m_tick;
    e.cnt   = m_cnt;
    return e;
  endfunction

  // One clock of stimulus: drive at the falling edge, advance the model, queue the expected response
  task automatic step(input logic rst_n, input logic [9:0] vp, input logic [1:0] rq, input logic [1:0] dn);
    @(negedge Clk);
    Rst         = rst_n;
    vpos        = vp;
    bus0.i_Req  = rq;
    bus0.i_Done = dn;
    bus1.i_Req  = rq;
    bus1.i_Done = dn;
    if (!rst_n) model_reset();
    else        model_step(vp, rq, dn);
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
  endtask

  // Monitor: after every rising edge compare both DUTs against the oldest queued expectation
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (q0.size() > 0 && q1.size() > 0) begin
        mon_cyc++;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        check($sformatf("dut0 cyc%0d", mon_cyc),
              32'({bus0.o_Grant, bus0.o_Abort, win0, busy0, tick0, cnt0}), 32'(e0));
        check($sformatf("dut1 cyc%0d", mon_cyc),
              32'({bus1.o_Grant, bus1.o_Abort, win1, busy1, tick1, cnt1}), 32'(e1));
        if (phase == 3 && bus0.o_Grant != 2'b00 && prev_g0 == 2'b00)
          order.push_back(int'(bus0.o_Grant[1]));
        if (phase == 5 && tick0) ticks++;
      end
      prev_g0 = bus0.o_Grant;
    end
  end

  int bnd[10] = '{478, 479, 480, 481, 482, 520, 521, 522, 523, 524};

  initial begin
    int         held;
    int         v;
    logic [1:0] dn, rq;
    Rst = 1'b0; vpos = '0;
    bus0.i_Req = 2'b00; bus0.i_Done = 2'b00;
    bus1.i_Req = 2'b00; bus1.i_Done = 2'b00;
    model_reset();

    // Reset, then a request outside the window
    phase = 1;
    repeat (3) step(1'b0, 10'd100, 2'b01, 2'b00);
    repeat (6) step(1'b1, 10'd100, 2'b01, 2'b00);
    check("t1 no grant", 32'(bus0.o_Grant), 32'd0);

    // Full-frame sweep with requester 0 holding its request
    phase = 2;
    for (int i = 0; i < 525; i++) step(1'b1, 10'(i), 2'b01, 2'b00);

    // Round-robin from a fresh reset
    repeat (2) step(1'b0, 10'd524, 2'b00, 2'b00);
    phase = 3;
    held  = 0;
    for (int i = 0; i < 40; i++) begin
      dn = 2'b00;
      if (m_owner[0] >= 0) begin
        held++;
        if (held == 3) dn[m_owner[0]] = 1'b1;
      end else begin
        held = 0;
      end
      step(1'b1, 10'd490, 2'b11, dn);
    end
    check("t3 grant count", 32'(order.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < order.size()) check($sformatf("t3 order%0d", i), 32'(order[i]), 32'(i % 2));

    // Hold without done: the short-timeout instance must abort
    phase = 4;
    repeat (2)  step(1'b1, 10'd490, 2'b00, 2'b00);
    repeat (20) step(1'b1, 10'd490, 2'b01, 2'b00);
    repeat (2)  step(1'b1, 10'd490, 2'b00, 2'b00);

    // Done from the non-owner, then done coinciding with the window closing
    phase = 6;
    repeat (2) step(1'b1, 10'd490, 2'b01, 2'b00);
    step(1'b1, 10'd490, 2'b01, 2'b10);
    step(1'b1, 10'd490, 2'b01, 2'b00);
    step(1'b1, 10'd523, 2'b01, 2'b00);
    step(1'b1, 10'd523, 2'b01, 2'b01);
    step(1'b1, 10'd523, 2'b00, 2'b00);
    check("t6 no abort", 32'({bus0.o_Abort, bus1.o_Abort}), 32'd0);

    // Asynchronous reset while a grant is held
    repeat (3) step(1'b1, 10'd490, 2'b01, 2'b00);
    check("pre-reset grant", 32'(bus0.o_Grant), 32'd1);
    step(1'b0, 10'd490, 2'b01, 2'b00);
    #1;
    check("async reset grant", 32'({bus0.o_Grant, bus1.o_Grant, bus0.o_Abort, bus1.o_Abort}), 32'd0);
    step(1'b0, 10'd490, 2'b01, 2'b00);

    // 257 shortened frames, with the line parked at 480 for several clocks each time
    phase = 5;
    for (int f = 0; f < 257; f++) begin
      step(1'b1, 10'd0, 2'($urandom_range(0, 3)), 2'b00);
      step(1'b1, 10'd479, 2'($urandom_range(0, 3)), 2'b00);
      repeat (3) step(1'b1, 10'd480, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      step(1'b1, 10'd523, 2'($urandom_range(0, 3)), 2'b00);
    end
    step(1'b1, 10'd0, 2'b00, 2'b00);
    check("t5 tick count", 32'(ticks), 32'd257);
    check("t5 frame count", 32'(cnt0), 32'd1);

    // Randomised traffic around the window edges with occasional resets
    phase = 7;
    v  = 470;
    rq = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) v = bnd[$urandom_range(0, 9)];
      else                           v = (v + 1) % 525;
      if ($urandom_range(0, 3) == 0) rq = 2'($urandom_range(0, 3));
      dn = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(($urandom_range(0, 499) != 0), 10'(v), rq, dn);
    end

    @(posedge Clk);
    #2;
    check("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
